// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory port, redirect port and the
// valid/ready decode-side head of the queue.
interface if_fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                       fetch_en;
  logic [31:0]                imem_addr;
  logic [31:0]                imem_rdata;
  logic                       redirect_valid;
  logic [31:0]                redirect_pc;
  logic                       out_valid;
  logic                       out_ready;
  logic [31:0]                out_instr;
  logic [31:0]                out_pc;
  logic [31:0]                out_pc4;
  logic [$clog2(DEPTH+1)-1:0] count;

  // Fetch stage side
  modport master (
    input  fetch_en, imem_rdata, redirect_valid, redirect_pc, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, out_pc4, count
  );

  // Memory / decode / branch-unit side
  modport slave (
    output fetch_en, imem_rdata, redirect_valid, redirect_pc, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, out_pc4, count
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: fetch PC register plus a DEPTH-entry FIFO of
// {instruction, PC} pairs feeding decode; redirect flushes and reloads the PC.
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                   clk,
  input  logic                   reset,
  if_fetch_queue_if.master       bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   pc_mem_d    [DEPTH];

  logic          out_valid_s;
  logic          full_s;
  logic          deq_s;
  logic          enq_s;
  logic [31:0]   redirect_tgt_s;

  assign out_valid_s    = (count_q != {CW{1'b0}});
  assign full_s         = (count_q == CW'(DEPTH));
  assign deq_s          = out_valid_s & bus.out_ready;
  // A full queue may still accept a fetch when decode drains the head the same cycle.
  assign enq_s          = bus.fetch_en & ~bus.redirect_valid & (~full_s | deq_s);
  assign redirect_tgt_s = bus.redirect_pc & 32'hFFFF_FFFC;

  // Next-state for PC, pointers, occupancy and storage
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      instr_mem_d[i] = instr_mem_q[i];
      pc_mem_d[i]    = pc_mem_q[i];
    end
    if (bus.redirect_valid) begin
      pc_d     = redirect_tgt_s;
      count_d  = {CW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
    end else begin
      if (enq_s) begin
        instr_mem_d[wr_ptr_q] = bus.imem_rdata;
        pc_mem_d[wr_ptr_q]    = pc_q;
        wr_ptr_d              = wr_ptr_q + PW'(1);
        pc_d                  = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(enq_s) - CW'(deq_s);
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      count_q  <= {CW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= 32'd0;
        pc_mem_q[i]    <= 32'd0;
      end
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= instr_mem_d[i];
        pc_mem_q[i]    <= pc_mem_d[i];
      end
    end
  end

  // Head of queue is read straight from storage and zeroed while empty.
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = out_valid_s;
  assign bus.out_instr = out_valid_s ? instr_mem_q[rd_ptr_q] : 32'd0;
  assign bus.out_pc    = out_valid_s ? pc_mem_q[rd_ptr_q] : 32'd0;
  assign bus.out_pc4   = out_valid_s ? (pc_mem_q[rd_ptr_q] + 32'd4) : 32'd0;
  assign bus.count     = count_q;
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised instruction-fetch stage for the pipelined MIPS core. It holds the fetch PC, drives the instruction-memory address, and buffers fetched instruction/PC pairs in a DEPTH-entry FIFO. Decode consumes entries through a valid/ready handshake. A redirect port is used for branches and jumps: it flushes the buffer and reloads the PC. This decouples fetch from decode stalls, which the single-register fetch stage cannot do.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, >= 2
RESET_PC, 32'h0000_3000, fetch PC loaded on reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
fetch_en  input  1  1 = fetch allowed this cycle; 0 = PC holds, no enqueue
imem_addr  output  32  current fetch PC (pc_q), combinational from register
imem_rdata  input  32  instruction word at imem_addr, combinational same cycle
redirect_valid  input  1  1 = branch/jump taken; flush and reload PC
redirect_pc  input  32  target PC; bits [1:0] ignored, forced to 00
out_valid  output  1  head entry valid (count != 0)
out_ready  input  1  decode accepts head this cycle
out_instr  output  32  head instruction; 0 when out_valid=0
out_pc  output  32  head PC; 0 when out_valid=0
out_pc4  output  32  head PC + 4 (mod 2^32); 0 when out_valid=0
count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

Behaviour:
- Reset (async, immediate): pc_q=RESET_PC, count=0, rd/wr pointers=0, storage cleared, out_valid=0, all out_* = 0.
- deq = out_valid & out_ready. A handshake completes on the clock edge.
- enq = fetch_en & ~redirect_valid & (count<DEPTH | deq).
- On enq: write {imem_rdata, pc_q} at wr_ptr; wr_ptr+1 (wraps mod DEPTH); pc_q <= pc_q+4 (wraps mod 2^32).
- On deq: rd_ptr+1 (wraps mod DEPTH).
- count_next = count + enq - deq.
- Full and deq in the same cycle: enq is allowed, count is unchanged.
- Empty: out_valid=0, so no deq is possible.
- Latency: an instruction fetched at edge N is presented at out_* after edge N (one cycle from fetch to decode visibility). After reset release, RESET_PC appears on out_pc after the first edge.
- Redirect (highest priority):
  - pc_q <= {redirect_pc[31:2],2'b00}; count, rd_ptr and wr_ptr go to 0; no enqueue that cycle.
  - Any deq in the same cycle still counts as delivered to decode. Decode squashes it if needed.
  - out_valid=0 in the cycle after a redirect. The target instruction appears one cycle later, provided fetch_en=1.
- fetch_en=0: pc_q holds and nothing is enqueued; dequeues continue. Redirect still applies.
- Full and ~deq: pc_q holds, imem_addr stable, nothing is enqueued.
- out_* are read combinationally from storage[rd_ptr] and gated to 0 when count=0.
- There is no internal state machine beyond pointers and count. Pointers are $clog2(DEPTH) bits.

Test Plan:
- Reset then fetch_en=1, out_ready=1, imem returns addr^32'hA5A5_0000 -> out_pc sequence 0x3000, 0x3004, 0x3008 on consecutive cycles; out_pc4=out_pc+4; count stays 1.
- out_ready=0, fetch_en=1 for 6 cycles -> count reaches 4 and holds; imem_addr stays 0x3010. Then out_ready=1 -> entries 0x3000..0x300C drain in order, and fetch resumes at 0x3010 with no gap.
- Full (count=4) with out_ready=1 -> simultaneous enq+deq; count stays 4; pointers wrap past DEPTH-1 with order preserved.
- Redirect to 0x0000_3407 while count=3 -> next cycle count=0, out_valid=0, imem_addr=0x3404; one cycle later out_pc=0x3404.
- Redirect asserted together with deq of head 0x3000 -> handshake counted; queue empty next cycle; no entry at 0x3004 is ever presented.
- pc_q=0xFFFF_FFFC enqueued -> out_pc4=0; next fetch address is 0x0000_0000. Assert reset mid-stream -> out_valid=0 and imem_addr=0x3000 immediately, before the next clock edge.
